// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the byte-memory sequencing arbiter.
// State encodings, bus widths and the latched command record.
// Imported by the arbiter top and its round-robin sub-block.
package memory_arbiter_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_SAMPLE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    // Transaction captured at grant; later requester changes are ignored.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/memory_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant decision, purely combinational.
// Latency: zero cycles; decision is consumed by the parent FSM in IDLE.
// Backpressure: none; enable gates the grant so busy periods never grant.
module rr_arbiter_2
    import memory_arbiter_pkg::*;
(
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic last_grant_i,
    input  logic enable_i,
    output logic grant_valid_o,
    output logic grant_o,
    output logic last_grant_o
);

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        grant_o = GNT_A;
        if (req_a_i && req_b_i) begin
            grant_o = ~last_grant_i;
        end else if (req_b_i) begin
            grant_o = GNT_B;
        end
        grant_valid_o = enable_i && (req_a_i || req_b_i);
        last_grant_o  = grant_valid_o ? grant_o : last_grant_i;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises two requesters onto one byte-memory port with setup/strobe/hold.
// Latency: write ack 3+STROBE_CYCLES cycles after grant edge, read ack 3 cycles.
// Backpressure: requests are only arbitrated in IDLE; others wait with req held.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    output logic              ack_a_o,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic              req_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    output logic              ack_b_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_store_o,
    input  logic [DATA_W-1:0] mem_q_i,
    output logic              busy_o
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        strb_cnt_q, strb_cnt_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    logic grant_valid;
    logic grant;
    logic last_grant_nxt;

    rr_arbiter_2 u_rr (
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == ST_IDLE),
        .grant_valid_o(grant_valid),
        .grant_o      (grant),
        .last_grant_o (last_grant_nxt)
    );

    // State and datapath registers; reset drops mem_store at once via state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            gnt_q        <= GNT_A;
            last_grant_q <= GNT_B;
            strb_cnt_q   <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            strb_cnt_q   <= strb_cnt_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
        end
    end

    // Next-state sequencing plus command capture, strobe count and read capture.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_nxt;
        strb_cnt_d   = strb_cnt_q;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    gnt_d   = grant;
                    cmd_d   = (grant == GNT_B) ? cmd_t'{we_b_i, addr_b_i, wdata_b_i}
                                               : cmd_t'{we_a_i, addr_a_i, wdata_a_i};
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = cmd_q.we ? ST_STROBE : ST_SAMPLE;
            ST_STROBE: begin
                if (strb_cnt_q == STROBE_LAST) begin
                    strb_cnt_d = '0;
                    state_d    = ST_HOLD;
                end else begin
                    strb_cnt_d = strb_cnt_q + 4'd1;
                end
            end
            ST_HOLD:   state_d = ST_DONE;
            ST_SAMPLE: begin
                if (gnt_q == GNT_B) begin
                    rdata_b_d = mem_q_i;
                end else begin
                    rdata_a_d = mem_q_i;
                end
                state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so store and acks are glitch-free.
    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        mem_store_o = (state_q == ST_STROBE);
        ack_a_o     = (state_q == ST_DONE) && (gnt_q == GNT_A);
        ack_b_o     = (state_q == ST_DONE) && (gnt_q == GNT_B);
    end

    assign mem_addr_o = cmd_q.addr;
    assign mem_data_o = cmd_q.wdata;
    assign rdata_a_o  = rdata_a_q;
    assign rdata_b_o  = rdata_b_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboarded bench for memory_arbiter with a latch-style byte memory model.
// Drivers push expected acks/stores; negedge monitors pop and compare.
// A second instance with STROBE_CYCLES=3 checks the stretched strobe.
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       req_a = 0, we_a = 0, req_b = 0, we_b = 0;
    logic [1:0] addr_a = 0, addr_b = 0;
    logic [7:0] wdata_a = 0, wdata_b = 0;
    logic       ack_a, ack_b, mem_store, busy;
    logic [7:0] rdata_a, rdata_b, mem_data, mem_q;
    logic [1:0] mem_addr;

    logic       req3 = 0;
    logic       ack_a3, ack_b3, store3, busy3;
    logic [7:0] rdata_a3, rdata_b3, data3;
    logic [1:0] addr3;
    logic [7:0] mem_q3 = 8'h00;

    logic [7:0] mem [4];
    initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    always @(mem_store or mem_addr or mem_data) if (mem_store) mem[mem_addr] = mem_data;
    assign mem_q = mem[mem_addr];

    memory_arbiter #(.STROBE_CYCLES(1)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_a_i(req_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
        .ack_a_o(ack_a), .rdata_a_o(rdata_a),
        .req_b_i(req_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
        .ack_b_o(ack_b), .rdata_b_o(rdata_b),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_store_o(mem_store),
        .mem_q_i(mem_q), .busy_o(busy)
    );

    memory_arbiter #(.STROBE_CYCLES(3)) dut3 (
        .clk_i(clk), .reset_i(reset),
        .req_a_i(req3), .we_a_i(1'b1), .addr_a_i(2'd1), .wdata_a_i(8'h3C),
        .ack_a_o(ack_a3), .rdata_a_o(rdata_a3),
        .req_b_i(1'b0), .we_b_i(1'b0), .addr_b_i(2'd0), .wdata_b_i(8'h00),
        .ack_b_o(ack_b3), .rdata_b_o(rdata_b3),
        .mem_addr_o(addr3), .mem_data_o(data3), .mem_store_o(store3),
        .mem_q_i(mem_q3), .busy_o(busy3)
    );

    typedef struct {
        bit         who;
        bit         rd;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;
    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } st_t;

    exp_t sb[$];
    st_t  stq[$];
    int   q3[$];
    int   total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Main monitor: ack scoreboard, strobe stability and completed-store checks.
    exp_t       e_mon;
    st_t        s_mon;
    logic [1:0] prev_addr = 0;
    logic [7:0] prev_data = 0;
    logic       prev_store = 0;
    int         run = 0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("ack_overlap", {31'd0, ack_a & ack_b}, 0);
            if (ack_a || ack_b) begin
                chk("ack_expected", {31'd0, sb.size() > 0}, 1);
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    chk("ack_who", {31'd0, ack_b}, {31'd0, e_mon.who});
                    chk("ack_cycle", cyc, e_mon.cyc);
                    if (e_mon.rd) chk("rdata", e_mon.who ? rdata_b : rdata_a, e_mon.rdata);
                end
            end
            if (mem_store) begin
                run++;
                chk("strobe_addr_stable", mem_addr, prev_addr);
                chk("strobe_data_stable", mem_data, prev_data);
            end else if (prev_store) begin
                chk("store_expected", {31'd0, stq.size() > 0}, 1);
                if (stq.size() > 0) begin
                    s_mon = stq.pop_front();
                    chk("store_addr", mem_addr, s_mon.addr);
                    chk("store_data", mem_data, s_mon.data);
                end
                chk("store_len", run, 1);
                run = 0;
            end
        end
        prev_addr  = mem_addr;
        prev_data  = mem_data;
        prev_store = mem_store;
    end

    // Monitor for the three-cycle strobe instance.
    int   run3 = 0;
    logic prev3 = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (store3) begin
                run3++;
                chk("strobe3_addr", addr3, 1);
            end else if (prev3) begin
                chk("strobe3_len", run3, 3);
                run3 = 0;
            end
            if (ack_a3) begin
                chk("ack3_expected", {31'd0, q3.size() > 0}, 1);
                if (q3.size() > 0) chk("ack3_cycle", cyc, q3.pop_front());
            end
        end
        prev3 = store3;
    end

    task automatic set_req(input bit who, input bit v);
        if (who) req_b = v; else req_a = v;
    endtask

    // Issue one transaction from an idle DUT, optionally perturbing its inputs after grant.
    task automatic do_txn(input bit who, input bit we, input logic [1:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input bit chg);
        int   k;
        bit   got;
        exp_t e;
        st_t  s;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        k = cyc;
        if (who) begin we_b = we; addr_b = a; wdata_b = d; end
        else     begin we_a = we; addr_a = a; wdata_a = d; end
        set_req(who, 1'b1);
        e.who = who; e.rd = !we; e.rdata = exp_rd; e.cyc = k + (we ? 4 : 3);
        sb.push_back(e);
        if (we) begin s.addr = a; s.data = d; stq.push_back(s); end
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (chg && cyc == k + 1) begin
                if (who) begin addr_b = 2'd3; wdata_b = 8'hFF; end
                else     begin addr_a = 2'd3; wdata_a = 8'hFF; end
            end
            if (who ? ack_b : ack_a) begin got = 1; break; end
        end
        set_req(who, 1'b0);
        chk("txn_completed", {31'd0, got}, 1);
        if (!got) begin sb.delete(); stq.delete(); end
    endtask

    initial begin
        int k;
        exp_t e;
        st_t  s;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_store", {31'd0, mem_store}, 0);
        chk("rst_acks", {30'd0, ack_a, ack_b}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_rdata_b", rdata_b, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_txn(1'b0, 1'b1, 2'd2, 8'hA5, 8'h00, 1'b0);
        do_txn(1'b0, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0);
        chk("rdata_b_untouched", rdata_b, 8'h00);

        do_txn(1'b1, 1'b1, 2'd1, 8'h5A, 8'h00, 1'b1);
        do_txn(1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b0);
        do_txn(1'b1, 1'b0, 2'd1, 8'h00, 8'h5A, 1'b0);
        chk("rdata_a_kept", rdata_a, 8'hA5);

        // Simultaneous held requests: grants alternate A, B, A, B.
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        k = cyc;
        we_a = 1; addr_a = 2'd0; wdata_a = 8'h11;
        we_b = 1; addr_b = 2'd1; wdata_b = 8'h22;
        req_a = 1; req_b = 1;
        for (int i = 0; i < 4; i++) begin
            e.who = i[0]; e.rd = 0; e.rdata = 0; e.cyc = k + 4 + 5 * i;
            sb.push_back(e);
            s.addr = i[0] ? 2'd1 : 2'd0; s.data = i[0] ? 8'h22 : 8'h11;
            stq.push_back(s);
        end
        while (cyc < k + 14) @(negedge clk);
        req_a = 0;
        while (cyc < k + 19) @(negedge clk);
        req_b = 0;

        // Stretched strobe on the second instance.
        @(negedge clk);
        k = cyc;
        req3 = 1;
        q3.push_back(k + 6);
        for (int i = 0; i < 30 && !ack_a3; i++) @(negedge clk);
        req3 = 0;
        repeat (2) @(negedge clk);
        chk("ack3_seen", q3.size(), 0);

        // Asynchronous reset in the middle of a strobe.
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        we_b = 1; addr_b = 2'd3; wdata_b = 8'h77; req_b = 1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("store_before_reset", {31'd0, mem_store}, 1);
        reset = 1'b1;
        #1;
        chk("arst_store", {31'd0, mem_store}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_data", mem_data, 0);
        chk("arst_rdata_a", rdata_a, 0);
        chk("arst_rdata_b", rdata_b, 0);
        @(negedge clk);
        req_b = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        do_txn(1'b0, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0);
        do_txn(1'b1, 1'b0, 2'd0, 8'h00, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        chk("acks_all_seen", sb.size(), 0);
        chk("stores_all_seen", stq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
